// File: rtl/match_sequencer.sv
// Table-driven compare-value sequencer for the 5-bit match counter.
// Steps through a programmable table on each rising edge of match_out, once or looping.
module match_sequencer #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW:0]      seq_len,
  input  logic             loop,
  input  logic             start,
  input  logic             abort,
  input  logic             match_out,
  output logic [WIDTH-1:0] match_in,
  output logic [AW-1:0]    step_idx,
  output logic             busy,
  output logic             done,
  output logic [7:0]       wrap_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  state_e           state_q, state_d;
  logic             mo_q;
  logic [AW:0]      len_q, len_d;
  logic             loop_q, loop_d;
  logic [WIDTH-1:0] match_in_q, match_in_d;
  logic [AW-1:0]    step_q, step_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       wrap_q, wrap_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             ev;
  logic             start_ok;
  logic             at_last;
  logic [AW-1:0]    step_nxt;

  assign ev       = match_out & ~mo_q;
  assign start_ok = start && (seq_len != '0) && (seq_len <= DEPTH_L);
  assign step_nxt = step_q + AW'(1);
  assign at_last  = ({1'b0, step_q} == (len_q - (AW+1)'(1)));

  // NOTE: table storage has no reset; software loads it before the first start.
  always_ff @(posedge clk) begin
    if (wr_en && (state_q == IDLE)) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mo_q       <= 1'b0;
      len_q      <= '0;
      loop_q     <= 1'b0;
      match_in_q <= '0;
      step_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wrap_q     <= '0;
    end else begin
      state_q    <= state_d;
      mo_q       <= match_out;
      len_q      <= len_d;
      loop_q     <= loop_d;
      match_in_q <= match_in_d;
      step_q     <= step_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wrap_q     <= wrap_d;
    end
  end

  // NOTE: every next-state signal is defaulted first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    loop_d     = loop_q;
    match_in_d = match_in_q;
    step_d     = step_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    wrap_d     = wrap_q;

    case (state_q)
      IDLE: begin
        // Table read sees the pre-edge contents, so a same-cycle write to entry 0 is not bypassed.
        if (start_ok) begin
          state_d    = RUN;
          len_d      = seq_len;
          loop_d     = loop;
          match_in_d = mem_q[0];
          step_d     = '0;
          wrap_d     = '0;
          busy_d     = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (ev) begin
          if (!at_last) begin
            step_d     = step_nxt;
            match_in_d = mem_q[step_nxt];
          end else if (loop_q) begin
            step_d     = '0;
            match_in_d = mem_q[0];
            if (wrap_q != 8'hFF) begin
              wrap_d = wrap_q + 8'd1;
            end
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign match_in = match_in_q;
  assign step_idx = step_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign wrap_cnt = wrap_q;

endmodule

// File: doc/match_sequencer.md
Name: match_sequencer

Overview:
Upstream companion to the 5-bit match counter. It holds a small programmable table of compare values and drives the counter's match_in port. The block steps to the next table entry on each new match_out event from the counter. It runs a table of 1..DEPTH entries once or in a continuous loop, and reports progress, completion and the number of completed loops.

Parameters:
WIDTH, 5, width of compare values (equals counter width)
DEPTH, 8, number of table entries
AW, 3, table address width (log2 DEPTH)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
wr_en  input  1  table write strobe; honoured only in IDLE
wr_addr  input  AW  table write address
wr_data  input  WIDTH  table write data
seq_len  input  AW+1  number of entries to run, sampled on accepted start
loop  input  1  1 = restart at entry 0 after last entry; sampled on accepted start
start  input  1  begin sequence; honoured only in IDLE
abort  input  1  stop a running sequence
match_out  input  1  match indication from counter
match_in  output  WIDTH  current compare value to counter (registered)
step_idx  output  AW  index of entry currently driven on match_in (registered)
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when a non-loop sequence completes
wrap_cnt  output  8  completed loops in current run, saturates at 255

Behaviour:
- Reset (async, active-high) clears all outputs to 0, state = IDLE, match_out history = 0, latched len = 0, latched loop = 0. Table contents are not reset.
- Table: DEPTH x WIDTH registers.
  - Write on a rising edge when wr_en=1 and state=IDLE.
  - wr_en in RUN is ignored, with no side effect.
- Event detect: ev = match_out & ~mo_q, where mo_q is match_out registered every cycle in all states. A level held high for several cycles produces exactly one event.
- FSM, two states: IDLE and RUN.
- IDLE:
  - start=1 with 1 <= seq_len <= DEPTH: on the next edge go to RUN; latch seq_len and loop; match_in <= table[0]; step_idx <= 0; wrap_cnt <= 0; busy <= 1.
  - start with seq_len=0 or seq_len>DEPTH is ignored; state stays IDLE.
  - start and wr_en in the same cycle: the write completes, and match_in loads table[0] as held before that edge (no bypass).
  - match_in and step_idx hold their last values in IDLE.
- RUN:
  - abort=1: next edge goes to IDLE; busy <= 0; done stays 0; match_in, step_idx and wrap_cnt hold. abort beats a simultaneous ev.
  - ev with step_idx < len-1: step_idx <= step_idx+1; match_in <= table[step_idx+1].
  - ev with step_idx = len-1 and loop=1: step_idx <= 0; match_in <= table[0]; wrap_cnt <= min(wrap_cnt+1, 255).
  - ev with step_idx = len-1 and loop=0: state <= IDLE; busy <= 0; done <= 1 for exactly one cycle; match_in and step_idx hold.
  - start in RUN is ignored.
- Latency: with ev in cycle N, the new match_in/step_idx are visible in cycle N+1. busy rises in the cycle after the accepted start.
- done is registered and is 0 in every cycle other than the completion pulse.
- seq_len=1 with loop=1: every event increments wrap_cnt and match_in stays table[0].
- Reset asserted mid-run: immediate return to the reset values listed above; no done pulse.

Test Plan:
- Reset/idle: assert rst for 30 ns, release -> match_in=0, busy=0, done=0, wrap_cnt=0; table writes in IDLE are accepted.
- Single run: table = {4,9,17}, seq_len=3, loop=0, start -> match_in 4, then 9 after the first match_out event, then 17 after the second; third event -> done pulses once, busy=0, match_in holds 17.
- Loop and saturation: seq_len=2, loop=1, table = {3,7}, drive 600 events -> match_in alternates 3/7; wrap_cnt counts to 255 and holds.
- Edge detect: hold match_out high 5 cycles in RUN -> exactly one step; toggle 1-0-1 -> two steps.
- Abort collision: in RUN, assert abort in the same cycle as the final-entry event (loop=0) -> IDLE next cycle, done stays 0, match_in holds the last value.
- Illegal and ignored inputs:
  - start with seq_len=0 or seq_len=9 -> stays IDLE.
  - wr_en to addr 0 during RUN -> table[0] unchanged, verified by the next run.
  - start+wr_en to addr 0 (data 21) in IDLE -> match_in shows the old table[0]; the next run shows 21.
